forward_scoreboard: RTL and testbench
=====================================

# forward_scoreboard

Parametrised forwarding and hazard unit for the multi-issue pipeline. It replaces the fixed two-stage, single-issue forwarding compare with a shift-register scoreboard of in-flight writers. The scoreboard covers ISSUE decode slots and DEPTH result stages. It also tracks a multi-cycle (mul/div) destination and raises a decode stall on load-use, intra-group and multi-cycle hazards.

## Interface
- ISSUE, 2, decode slots per group (1..4); slot 0 is the oldest.
- DEPTH, 3, tracked stages after decode (stage 0 = E, 1 = M, 2 = W).
- REG_W, 5, register index width.
- FS_W, $clog2(DEPTH+1), forward-select width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears every record and md_busy.
- stall_i  in  1  back-end hold; the scoreboard freezes.
- flush_i  in  1  kills all records in stages 0..DEPTH-2 and md_busy.
- issue_valid  in  ISSUE  slot holds a real instruction.
- issue_srca, issue_srcb  in  ISSUE×REG_W  source registers.
- issue_dst  in  ISSUE×REG_W  destination register.
- issue_wen  in  ISSUE  slot writes issue_dst.
- issue_rdy  in  ISSUE×2  first stage index whose output holds the result (0 = ALU, 1 = load).
- issue_md  in  ISSUE  slot is a multi-cycle op; its result arrives via md_done.
- md_done  in  1  multi-cycle result written to the regfile this cycle.
- fwd_a, fwd_b  out  ISSUE×FS_W  0 = regfile; k = forward from stage k-1.
- stall_o  out  1  decode group is not accepted this cycle.

## Operation
- Record per stage s and slot i: valid, dst, rdy. A record "matches" source r when valid, wen, dst == r and r != 0.
- Forward select per source: the youngest matching record wins. The lowest stage is youngest; within a stage, the higher slot is youngest. The select is s+1. With no match, the select is 0.
- Hazard per source:
  - the winning record has rdy > s (not yet produced), or
  - md_busy and the source == md_reg != 0, or
  - an older valid slot in the same group writes that source (intra-group RAW).
- stall_o = OR of the hazards over valid slots, plus (md_busy and any valid issue_md). The whole group stalls; slots never issue partially.
- Accept = !stall_o && !stall_i.
- Advance when !stall_i: stage s+1 ← stage s, and the stage DEPTH-1 record drops out. Stage 0 ← the issue group if accepted, otherwise a bubble (all valid = 0).
- stall_i = 1: all records and md state hold. Outputs are still evaluated.
- flush_i (priority over advance):
  - stages 0..DEPTH-2 are cleared, and stage DEPTH-1 becomes the old stage DEPTH-2 cleared, i.e. all invalid;
  - the retiring W record is unaffected because it commits this cycle;
  - the issue group is not accepted;
  - md_busy clears.
- MD tracking:
  - on accept of a slot with issue_md && issue_wen, set md_busy and md_reg ← issue_dst;
  - md_done clears md_busy;
  - md_done and a new md accept in the same cycle leave md_busy = 1 with the new reg. This cannot occur with correct stall_o, but must be handled this way.
- Reset values: all records invalid, md_busy = 0, md_reg = 0. After reset, fwd_a = fwd_b = 0 and stall_o = 0 for any issue without md.

## Timing
- fwd_* and stall_o are combinational from the registered scoreboard and the current issue inputs. They are valid in the same cycle.
- A record is visible for forwarding the cycle after accept, at stage 0.
- ALU producer to an immediately following consumer: forward from E (select 1), zero stall.
- Load (rdy = 1) to an immediate consumer: 1 stall cycle, then forward from M (select 2).
- A consumer of md_reg stalls until the cycle after md_done.

## Test plan
- Reset, then issue slot0 add r3←r1,r2 (rdy 0), then slot0 srca = 3 next cycle -> stall_o = 0, fwd_a[0] = 1. One cycle later, with another srca = 3 -> fwd_a = 2.
- Load r5 (rdy 1), next group srcb = 5 -> stall_o = 1 for exactly one cycle, then fwd_b = 2 with stall_o = 0.
- Same group: slot0 writes r7, slot1 srca = 7 -> stall_o = 1. Next cycle slot1 alone -> fwd_a[1] = 1.
- Records in E and M both write r4, consumer srca = 4 -> fwd_a = 1 (youngest). Source r0 with writer dst = 0 -> fwd = 0, no stall.
- div r9 accepted, consumer srca = 9 -> stall_o held 10 cycles until md_done pulses, then stall_o = 0 the cycle after. A second div during busy -> stall_o = 1.
- Scoreboard full of writers to r6, then flush_i -> consumer srca = 6 next cycle gives fwd_a = 0, stall_o = 0. stall_i held 3 cycles -> selects unchanged across the hold. Reset mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Forwarding/hazard scoreboard for a multi-issue pipeline.
// Tracks in-flight writers per stage and slot, plus one multi-cycle destination.
module forward_scoreboard #(
  parameter int ISSUE = 2,
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int FS_W  = $clog2(DEPTH+1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall_i,
  input  logic                             flush_i,
  input  logic [ISSUE-1:0]                 issue_valid,
  input  logic [ISSUE-1:0][REG_W-1:0]      issue_srca,
  input  logic [ISSUE-1:0][REG_W-1:0]      issue_srcb,
  input  logic [ISSUE-1:0][REG_W-1:0]      issue_dst,
  input  logic [ISSUE-1:0]                 issue_wen,
  input  logic [ISSUE-1:0][1:0]            issue_rdy,
  input  logic [ISSUE-1:0]                 issue_md,
  input  logic                             md_done,
  output logic [ISSUE-1:0][FS_W-1:0]       fwd_a,
  output logic [ISSUE-1:0][FS_W-1:0]       fwd_b,
  output logic                             stall_o
);

  logic [DEPTH-1:0][ISSUE-1:0]             rec_v;
  logic [DEPTH-1:0][ISSUE-1:0][REG_W-1:0]  rec_dst;
  logic [DEPTH-1:0][ISSUE-1:0][1:0]        rec_rdy;
  logic                                    md_busy;
  logic [REG_W-1:0]                        md_reg;

  logic [ISSUE-1:0][FS_W:0]                look_a;
  logic [ISSUE-1:0][FS_W:0]                look_b;
  logic                                    accept;
  logic                                    md_set;
  logic [REG_W-1:0]                        md_dst;

  // Returns {late, select}; the scan runs oldest to youngest so the last hit wins.
  function automatic logic [FS_W:0] lookup(input logic [REG_W-1:0] r);
    logic [FS_W-1:0] sel;
    logic            late;
    sel  = '0;
    late = 1'b0;
    for (int s = DEPTH-1; s >= 0; s--) begin
      for (int j = 0; j < ISSUE; j++) begin
        if (rec_v[s][j] && rec_dst[s][j] == r && r != '0) begin
          sel  = FS_W'(s + 1);
          late = int'(rec_rdy[s][j]) > s;
        end
      end
    end
    return {late, sel};
  endfunction

  function automatic logic raw(input int i, input logic [REG_W-1:0] r);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < ISSUE; j++) begin
      if (j < i && issue_valid[j] && issue_wen[j] &&
          issue_dst[j] == r && r != '0)
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic md_hit(input logic [REG_W-1:0] r);
    return md_busy && md_reg != '0 && r == md_reg;
  endfunction

  always_comb begin
    stall_o = 1'b0;
    look_a  = '0;
    look_b  = '0;
    fwd_a   = '0;
    fwd_b   = '0;
    for (int i = 0; i < ISSUE; i++) begin
      look_a[i] = lookup(issue_srca[i]);
      look_b[i] = lookup(issue_srcb[i]);
      fwd_a[i]  = look_a[i][FS_W-1:0];
      fwd_b[i]  = look_b[i][FS_W-1:0];
      if (issue_valid[i] &&
          (look_a[i][FS_W] || look_b[i][FS_W] ||
           md_hit(issue_srca[i]) || md_hit(issue_srcb[i]) ||
           raw(i, issue_srca[i]) || raw(i, issue_srcb[i]) ||
           (md_busy && issue_md[i])))
        stall_o = 1'b1;
    end
  end

  always_comb begin
    md_set = 1'b0;
    md_dst = '0;
    for (int i = 0; i < ISSUE; i++) begin
      if (issue_valid[i] && issue_md[i] && issue_wen[i]) begin
        md_set = 1'b1;
        md_dst = issue_dst[i];
      end
    end
  end

  assign accept = !stall_o && !stall_i && !flush_i;

  // Multi-cycle results come back through md_done, never through the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_v   <= '0;
      rec_dst <= '0;
      rec_rdy <= '0;
      md_busy <= 1'b0;
      md_reg  <= '0;
    end else if (flush_i) begin
      rec_v   <= '0;
      md_busy <= 1'b0;
    end else if (!stall_i) begin
      for (int s = DEPTH-1; s >= 1; s--) begin
        rec_v[s]   <= rec_v[s-1];
        rec_dst[s] <= rec_dst[s-1];
        rec_rdy[s] <= rec_rdy[s-1];
      end
      rec_v[0]   <= accept ? (issue_valid & issue_wen & ~issue_md) : '0;
      rec_dst[0] <= issue_dst;
      rec_rdy[0] <= issue_rdy;
      if (accept && md_set) begin
        md_busy <= 1'b1;
        md_reg  <= md_dst;
      end else if (md_done) begin
        md_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard.
// Driver queues expected outputs; a negedge monitor pops and compares.
module tb_forward_scoreboard;
  localparam int ISSUE = 2;
  localparam int DEPTH = 3;
  localparam int REG_W = 5;
  localparam int FS_W  = 2;

  logic clk = 1'b0;
  logic reset, stall_i, flush_i, md_done;
  logic [ISSUE-1:0]            issue_valid, issue_wen, issue_md;
  logic [ISSUE-1:0][REG_W-1:0] issue_srca, issue_srcb, issue_dst;
  logic [ISSUE-1:0][1:0]       issue_rdy;
  logic [ISSUE-1:0][FS_W-1:0]  fwd_a, fwd_b;
  logic                        stall_o;

  forward_scoreboard #(
    .ISSUE(ISSUE), .DEPTH(DEPTH), .REG_W(REG_W), .FS_W(FS_W)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .issue_valid(issue_valid), .issue_srca(issue_srca),
    .issue_srcb(issue_srcb), .issue_dst(issue_dst),
    .issue_wen(issue_wen), .issue_rdy(issue_rdy),
    .issue_md(issue_md), .md_done(md_done),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic [3:0] fa;
    logic [3:0] fb;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      total++;
      if ({stall_o, fwd_a, fwd_b} !== e) begin
        bad++;
        $display("FAIL %s: got stall=%0b fa=%h fb=%h, want stall=%0b fa=%h fb=%h",
                 n, stall_o, fwd_a, fwd_b, e.s, e.fa, e.fb);
      end
    end
  end

  task automatic idle();
    reset       = 1'b0;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    md_done     = 1'b0;
    issue_valid = '0;
    issue_wen   = '0;
    issue_md    = '0;
    issue_srca  = '0;
    issue_srcb  = '0;
    issue_dst   = '0;
    issue_rdy   = '0;
  endtask

  task automatic wr(input int i, input int d, input int r);
    issue_valid[i] = 1'b1;
    issue_wen[i]   = 1'b1;
    issue_dst[i]   = REG_W'(d);
    issue_rdy[i]   = 2'(r);
  endtask

  task automatic rd(input int i, input int a, input int b);
    issue_valid[i] = 1'b1;
    issue_srca[i]  = REG_W'(a);
    issue_srcb[i]  = REG_W'(b);
  endtask

  task automatic tick(input logic chk, input logic s,
                      input logic [3:0] fa, input logic [3:0] fb,
                      input string n);
    if (chk) begin
      q.push_back({s, fa, fb});
      nq.push_back(n);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(0, 0, 0, 0, "");
    reset = 1'b1;
    tick(0, 0, 0, 0, "");
    tick(1, 0, 4'h0, 4'h0, "reset_state");

    // ALU producer, consumers at E, M, W and after retire
    wr(0, 3, 0); rd(0, 1, 2);
    tick(1, 0, 4'h0, 4'h0, "alu_issue");
    rd(0, 3, 0);
    tick(1, 0, 4'h1, 4'h0, "alu_fwd_e");
    rd(0, 3, 0);
    tick(1, 0, 4'h2, 4'h0, "alu_fwd_m");
    rd(0, 3, 0);
    tick(1, 0, 4'h3, 4'h0, "alu_fwd_w");
    rd(0, 3, 0);
    tick(1, 0, 4'h0, 4'h0, "alu_retired");

    // load-use
    wr(0, 5, 1);
    tick(1, 0, 4'h0, 4'h0, "load_issue");
    rd(0, 0, 5);
    tick(1, 1, 4'h0, 4'h1, "load_use_stall");
    rd(0, 0, 5);
    tick(1, 0, 4'h0, 4'h2, "load_fwd_m");

    // intra-group RAW
    wr(0, 7, 0); rd(1, 7, 0);
    tick(1, 1, 4'h0, 4'h0, "intra_raw");
    wr(0, 7, 0);
    tick(1, 0, 4'h0, 4'h0, "intra_slot0");
    rd(1, 7, 0);
    tick(1, 0, 4'h4, 4'h0, "intra_slot1_fwd");

    // youngest match wins; r0 never forwards
    wr(0, 4, 0);
    tick(1, 0, 4'h0, 4'h0, "y_w0");
    wr(1, 4, 0);
    tick(1, 0, 4'h0, 4'h0, "y_w1");
    rd(0, 4, 0); rd(1, 4, 0);
    tick(1, 0, 4'h5, 4'h0, "youngest_e");
    wr(0, 0, 0); rd(0, 0, 4);
    tick(1, 0, 4'h0, 4'h2, "youngest_m");
    rd(0, 0, 0);
    tick(1, 0, 4'h0, 4'h0, "r0_no_fwd");

    // multi-cycle op
    wr(0, 9, 0); issue_md[0] = 1'b1;
    tick(1, 0, 4'h0, 4'h0, "md_issue");
    wr(0, 11, 0); issue_md[0] = 1'b1;
    tick(1, 1, 4'h0, 4'h0, "md_second_busy");
    for (int k = 0; k < 10; k++) begin
      rd(0, 9, 0);
      if (k == 9) md_done = 1'b1;
      tick(1, 1, 4'h0, 4'h0, "md_wait");
    end
    rd(0, 9, 0);
    tick(1, 0, 4'h0, 4'h0, "md_released");

    // flush
    for (int k = 0; k < 3; k++) begin
      wr(0, 6, 0); wr(1, 6, 0);
      tick(0, 0, 0, 0, "");
    end
    flush_i = 1'b1; rd(0, 6, 0);
    tick(1, 0, 4'h1, 4'h0, "pre_flush");
    rd(0, 6, 0);
    tick(1, 0, 4'h0, 4'h0, "post_flush");

    // back-end hold
    wr(0, 8, 1);
    tick(1, 0, 4'h0, 4'h0, "hold_load");
    for (int k = 0; k < 3; k++) begin
      stall_i = 1'b1; rd(0, 8, 0);
      tick(1, 1, 4'h1, 4'h0, "hold_frozen");
    end
    rd(0, 8, 0);
    tick(1, 1, 4'h1, 4'h0, "hold_release");
    rd(0, 8, 0);
    tick(1, 0, 4'h2, 4'h0, "hold_advance");

    // reset in the middle of a stall
    wr(0, 12, 1);
    tick(1, 0, 4'h0, 4'h0, "rst_load");
    reset = 1'b1; rd(0, 12, 0);
    tick(1, 1, 4'h1, 4'h0, "rst_stall");
    rd(0, 12, 0);
    tick(1, 0, 4'h0, 4'h0, "rst_cleared");

    repeat (2) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
